// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: writeback source encodings, register-zero index
// and default datapath widths.
package pipeline_defs;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'b00,
        WB_SRC_MEM  = 2'b01,
        WB_SRC_LINK = 2'b10,
        WB_SRC_RSVD = 2'b11
    } wb_src_e;

endpackage

// File: rtl/wb_regfile_wb_select.sv
// Writeback source mux; the reserved encoding falls back to the ALU result.
module wb_select
    import pipeline_defs::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] link_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = alu_i;
        case (wb_src_e'(sel_i))
            WB_SRC_MEM:  data_o = mem_i;
            WB_SRC_LINK: data_o = link_i;
            default:     data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file with write-through read
// ports, a registered debug port and a committed-write counter.
module wb_regfile
    import pipeline_defs::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              inRegWrite,
    input  logic [1:0]        inMemtoReg,
    input  logic [DATA_W-1:0] inAluLatch,
    input  logic [DATA_W-1:0] inLoadWordDividerMEM,
    input  logic [DATA_W-1:0] inLinkAddr,
    input  logic [ADDR_W-1:0] inMuxRtRd,
    input  logic [ADDR_W-1:0] inRegRs,
    input  logic [ADDR_W-1:0] inRegRt,
    input  logic [ADDR_W-1:0] inDbgAddr,
    output logic [DATA_W-1:0] outRsData,
    output logic [DATA_W-1:0] outRtData,
    output logic [DATA_W-1:0] outDbgData,
    output logic [DATA_W-1:0] outWbData,
    output logic [ADDR_W-1:0] outWbDest,
    output logic              outWbValid,
    output logic [15:0]       outWriteCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] dbg_q, dbg_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] wb_data_c;
    logic              wr_c;

    wb_select #(.DATA_W(DATA_W)) u_wb_select (
        .sel_i  (inMemtoReg),
        .alu_i  (inAluLatch),
        .mem_i  (inLoadWordDividerMEM),
        .link_i (inLinkAddr),
        .data_o (wb_data_c)
    );

    assign wr_c = inRegWrite & enable & (inMuxRtRd != ZERO_IDX);

    // Write-through read ports: the commit in flight is visible before the edge.
    always_comb begin
        outRsData = '0;
        outRtData = '0;
        if (inRegRs != ZERO_IDX) begin
            outRsData = (wr_c && (inRegRs == inMuxRtRd)) ? wb_data_c : regs_q[inRegRs];
        end
        if (inRegRt != ZERO_IDX) begin
            outRtData = (wr_c && (inRegRt == inMuxRtRd)) ? wb_data_c : regs_q[inRegRt];
        end
    end

    // Debug capture reads storage directly, so a same-cycle write shows the old value.
    always_comb begin
        dbg_d = (inDbgAddr == ZERO_IDX) ? '0 : regs_q[inDbgAddr];
        cnt_d = wr_c ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            dbg_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_c) begin
                regs_q[inMuxRtRd] <= wb_data_c;
            end
            dbg_q <= dbg_d;
            cnt_q <= cnt_d;
        end
    end

    assign outWbData     = wb_data_c;
    assign outWbValid    = wr_c;
    assign outWbDest     = wr_c ? inMuxRtRd : '0;
    assign outDbgData    = dbg_q;
    assign outWriteCount = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        inRegWrite;
    logic [1:0]  inMemtoReg;
    logic [31:0] inAluLatch;
    logic [31:0] inLoadWordDividerMEM;
    logic [31:0] inLinkAddr;
    logic [4:0]  inMuxRtRd;
    logic [4:0]  inRegRs;
    logic [4:0]  inRegRt;
    logic [4:0]  inDbgAddr;
    logic [31:0] outRsData;
    logic [31:0] outRtData;
    logic [31:0] outDbgData;
    logic [31:0] outWbData;
    logic [4:0]  outWbDest;
    logic        outWbValid;
    logic [15:0] outWriteCount;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .inRegWrite           (inRegWrite),
        .inMemtoReg           (inMemtoReg),
        .inAluLatch           (inAluLatch),
        .inLoadWordDividerMEM (inLoadWordDividerMEM),
        .inLinkAddr           (inLinkAddr),
        .inMuxRtRd            (inMuxRtRd),
        .inRegRs              (inRegRs),
        .inRegRt              (inRegRt),
        .inDbgAddr            (inDbgAddr),
        .outRsData            (outRsData),
        .outRtData            (outRtData),
        .outDbgData           (outDbgData),
        .outWbData            (outWbData),
        .outWbDest            (outWbDest),
        .outWbValid           (outWbValid),
        .outWriteCount        (outWriteCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle; inputs change at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] sel_exp [4];

    initial begin
        sel_exp[0] = 32'hA; sel_exp[1] = 32'hB; sel_exp[2] = 32'hC; sel_exp[3] = 32'hA;

        rst_n = 1'b0; enable = 1'b1; inRegWrite = 1'b0; inMemtoReg = 2'b00;
        inAluLatch = '0; inLoadWordDividerMEM = '0; inLinkAddr = '0;
        inMuxRtRd = '0; inRegRs = 5'd5; inRegRt = 5'd5; inDbgAddr = 5'd5;
        #12;
        check("reset_rs", outRsData, 32'h0);
        check("reset_cnt", 32'(outWriteCount), 32'h0);
        check("reset_dbg", outDbgData, 32'h0);

        // Write r5 then assert reset mid-cycle.
        @(negedge clk);
        rst_n = 1'b1;
        inRegWrite = 1'b1; inMuxRtRd = 5'd5; inAluLatch = 32'h1234;
        tick();
        inRegWrite = 1'b0;
        #1;
        check("r5_written", outRsData, 32'h1234);
        check("cnt_after_r5", 32'(outWriteCount), 32'h1);
        tick();
        check("dbg_r5", outDbgData, 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rs", outRsData, 32'h0);
        check("async_rst_rt", outRtData, 32'h0);
        check("async_rst_cnt", 32'(outWriteCount), 32'h0);
        check("async_rst_dbg", outDbgData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Source select sequence on r7.
        inMuxRtRd = 5'd7; inRegRs = 5'd7; inRegRt = 5'd0;
        inAluLatch = 32'hA; inLoadWordDividerMEM = 32'hB; inLinkAddr = 32'hC;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            inMemtoReg = 2'(s); inRegWrite = 1'b1;
            #1;
            check("sel_wbdata", outWbData, sel_exp[s]);
            check("sel_valid", 32'(outWbValid), 32'h1);
            check("sel_dest", 32'(outWbDest), 32'd7);
            check("sel_rt_r0", outRtData, 32'h0);
            tick();
            inRegWrite = 1'b0;
            #1;
            check("sel_r7_stored", outRsData, sel_exp[s]);
        end
        check("sel_cnt", 32'(outWriteCount), 32'd4);

        // Bypass on both ports to r9.
        @(negedge clk);
        inMemtoReg = 2'b00; inAluLatch = 32'hDEADBEEF; inMuxRtRd = 5'd9;
        inRegRs = 5'd9; inRegRt = 5'd9; inRegWrite = 1'b1;
        #1;
        check("byp_rs", outRsData, 32'hDEADBEEF);
        check("byp_rt", outRtData, 32'hDEADBEEF);
        tick();
        inRegWrite = 1'b0;
        #1;
        check("byp_rs_stored", outRsData, 32'hDEADBEEF);
        check("byp_rt_stored", outRtData, 32'hDEADBEEF);
        inRegRs = 5'd7;
        #1;
        check("distinct_rs_r7", outRsData, 32'hA);
        check("distinct_rt_r9", outRtData, 32'hDEADBEEF);
        check("byp_cnt", 32'(outWriteCount), 32'd5);

        // Writes to r0 are discarded.
        @(negedge clk);
        inAluLatch = 32'hFFFFFFFF; inMuxRtRd = 5'd0; inRegRs = 5'd0; inRegWrite = 1'b1;
        #1;
        check("r0_valid", 32'(outWbValid), 32'h0);
        check("r0_dest", 32'(outWbDest), 32'h0);
        check("r0_wbdata", outWbData, 32'hFFFFFFFF);
        check("r0_read", outRsData, 32'h0);
        tick();
        inRegWrite = 1'b0;
        #1;
        check("r0_read_after", outRsData, 32'h0);
        check("r0_cnt", 32'(outWriteCount), 32'd5);

        // Stall: no bypass, no commit.
        @(negedge clk);
        enable = 1'b0; inRegWrite = 1'b1; inMuxRtRd = 5'd3; inAluLatch = 32'h55;
        inRegRs = 5'd3; inRegRt = 5'd3;
        #1;
        check("stall_rs", outRsData, 32'h0);
        check("stall_rt", outRtData, 32'h0);
        check("stall_valid", 32'(outWbValid), 32'h0);
        check("stall_dest", 32'(outWbDest), 32'h0);
        tick();
        check("stall_r3_held", outRsData, 32'h0);
        check("stall_cnt", 32'(outWriteCount), 32'd5);
        enable = 1'b1;
        #1;
        check("unstall_byp", outRsData, 32'h55);
        tick();
        inRegWrite = 1'b0;
        #1;
        check("unstall_r3", outRsData, 32'h55);
        check("unstall_cnt", 32'(outWriteCount), 32'd6);

        // Drive the counter to 0xFFFF with repeated r1 writes.
        @(negedge clk);
        inMuxRtRd = 5'd1; inAluLatch = 32'h1111; inRegWrite = 1'b1;
        repeat (65535 - 6) @(posedge clk);
        @(negedge clk);
        inRegWrite = 1'b0;
        #1;
        check("cnt_ffff", 32'(outWriteCount), 32'h0000FFFF);

        // r31 write wraps the counter; debug sees the pre-write value that edge.
        @(negedge clk);
        inMuxRtRd = 5'd31; inAluLatch = 32'h77; inDbgAddr = 5'd31; inRegWrite = 1'b1;
        tick();
        inRegWrite = 1'b0;
        #1;
        check("cnt_wrap", 32'(outWriteCount), 32'h0);
        check("dbg_same_cycle_old", outDbgData, 32'h0);
        tick();
        check("dbg_r31", outDbgData, 32'h77);
        inDbgAddr = 5'd0;
        tick();
        check("dbg_r0", outDbgData, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        fails++;
        $display("FAIL timeout: simulation exceeded its time budget");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
